// File: rtl/osd_mam_resp_pkg.sv
// Shared types and helpers for the MAM memory responder.
package osd_mam_resp_pkg;

  localparam int unsigned LANES      = 4;
  localparam int unsigned LANE_IDX_W = 2;
  localparam int unsigned BEAT_W     = 16;
  localparam int unsigned STRB_W     = 2;
  localparam int unsigned BEATS_W    = 14;

  typedef enum logic [2:0] {
    IDLE,
    WR_COLLECT,
    WR_MEM,
    RD_MEM,
    RD_WAIT,
    RD_DRAIN
  } state_t;

  typedef struct packed {
    logic [BEAT_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } beat_t;

  // Swap the two bytes of a beat and keep each strobe bit with its byte.
  function automatic beat_t endian_swap16(input logic [BEAT_W-1:0] data,
                                          input logic [STRB_W-1:0] strb);
    beat_t b;
    b.data = {data[7:0], data[15:8]};
    b.strb = {strb[0], strb[1]};
    return b;
  endfunction

endpackage

// File: rtl/osd_mam_mem_responder.sv
// MAM target endpoint: packs 16-bit beats into 64-bit memory words and
// unpacks memory words into 16-bit read beats, one access outstanding.
module osd_mam_mem_responder
  import osd_mam_resp_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned MEM_DATA_WIDTH = 64,
  parameter int unsigned ENDIAN         = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_rw,
  input  logic [ADDR_WIDTH-1:0]       req_addr,
  input  logic                        req_burst,
  input  logic [BEATS_W-1:0]          req_beats,
  input  logic                        write_valid,
  output logic                        write_ready,
  input  logic [DATA_WIDTH-1:0]       write_data,
  input  logic [DATA_WIDTH/8-1:0]     write_strb,
  output logic                        read_valid,
  input  logic                        read_ready,
  output logic [DATA_WIDTH-1:0]       read_data,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic                        mem_req_we,
  output logic [ADDR_WIDTH-1:0]       mem_req_addr,
  output logic [MEM_DATA_WIDTH-1:0]   mem_req_wdata,
  output logic [MEM_DATA_WIDTH/8-1:0] mem_req_wmask,
  input  logic                        mem_rsp_valid,
  input  logic [MEM_DATA_WIDTH-1:0]   mem_rsp_rdata,
  output logic                        busy
);

  localparam int unsigned MASK_W = MEM_DATA_WIDTH / 8;

  if (DATA_WIDTH != BEAT_W || MEM_DATA_WIDTH != LANES * BEAT_W) begin : g_bad_width
    $error("osd_mam_mem_responder: DATA_WIDTH must be 16 and MEM_DATA_WIDTH 64");
  end

  state_t                               state, state_next;
  logic                                 out_of_reset;
  logic [ADDR_WIDTH-1:0]                word_addr;
  logic [LANE_IDX_W-1:0]                lane;
  logic [BEATS_W-1:0]                   remaining;
  logic [LANES-1:0][BEAT_W-1:0]         buffer;
  logic [LANES-1:0][STRB_W-1:0]         mask;
  logic [LANES-1:0][BEAT_W-1:0]         rdata;
  beat_t                                wr_beat;
  beat_t                                rd_beat;

  logic req_fire, wr_fire, flush_done, rdreq_fire, rsp_fire, rd_fire;
  logic last_beat, last_lane;

  assign req_fire   = (state == IDLE) && out_of_reset && req_valid;
  assign wr_fire    = (state == WR_COLLECT) && write_valid;
  assign flush_done = (state == WR_MEM) && ((mask == '0) || mem_req_ready);
  assign rdreq_fire = (state == RD_MEM) && mem_req_ready;
  assign rsp_fire   = (state == RD_WAIT) && mem_rsp_valid;
  assign rd_fire    = (state == RD_DRAIN) && read_ready;
  assign last_beat  = (remaining == BEATS_W'(1));
  assign last_lane  = (lane == LANE_IDX_W'(LANES - 1));

  // Byte-order adjustment of the incoming write beat and outgoing read beat.
  always_comb begin
    wr_beat = '{data: write_data, strb: write_strb};
    rd_beat = '{data: rdata[lane], strb: '0};
    if (ENDIAN != 0) begin
      wr_beat = endian_swap16(write_data, write_strb);
      rd_beat = endian_swap16(rdata[lane], '0);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      out_of_reset <= 1'b0;
    end else begin
      state        <= state_next;
      out_of_reset <= 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (req_fire) state_next = req_rw ? WR_COLLECT : RD_MEM;
      WR_COLLECT: if (wr_fire && (last_lane || last_beat)) state_next = WR_MEM;
      WR_MEM:     if (flush_done) state_next = (remaining != '0) ? WR_COLLECT : IDLE;
      RD_MEM:     if (rdreq_fire) state_next = RD_WAIT;
      RD_WAIT:    if (rsp_fire) state_next = RD_DRAIN;
      RD_DRAIN: begin
        if (rd_fire) begin
          if (last_beat)      state_next = IDLE;
          else if (last_lane) state_next = RD_MEM;
        end
      end
      default:    state_next = IDLE;
    endcase
  end

  // Outputs decoded purely from registered state and datapath.
  always_comb begin
    req_ready     = 1'b0;
    write_ready   = 1'b0;
    read_valid    = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_wmask = '0;
    busy          = (state != IDLE);
    mem_req_addr  = word_addr;
    mem_req_wdata = buffer;
    read_data     = rd_beat.data;
    case (state)
      IDLE:       req_ready = out_of_reset;
      WR_COLLECT: write_ready = 1'b1;
      WR_MEM: begin
        mem_req_valid = (mask != '0);
        mem_req_we    = 1'b1;
        mem_req_wmask = MASK_W'(mask);
      end
      RD_MEM:     mem_req_valid = 1'b1;
      RD_DRAIN:   read_valid = 1'b1;
      default:    ;
    endcase
  end

  // Word buffer, byte mask, lane/beat counters and word address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_addr <= '0;
      lane      <= '0;
      remaining <= '0;
      buffer    <= '0;
      mask      <= '0;
      rdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_fire) begin
            word_addr <= req_addr & ~ADDR_WIDTH'(7);
            lane      <= req_addr[2:1];
            remaining <= (req_burst && req_beats != '0) ? req_beats : BEATS_W'(1);
          end
        end
        WR_COLLECT: begin
          if (wr_fire) begin
            buffer[lane] <= wr_beat.data;
            mask[lane]   <= wr_beat.strb;
            remaining    <= remaining - BEATS_W'(1);
            lane         <= lane + LANE_IDX_W'(1);
          end
        end
        WR_MEM: begin
          if (flush_done) begin
            buffer    <= '0;
            mask      <= '0;
            word_addr <= word_addr + ADDR_WIDTH'(8);
            lane      <= '0;
          end
        end
        RD_WAIT: if (rsp_fire) rdata <= mem_rsp_rdata;
        RD_DRAIN: begin
          if (rd_fire) begin
            remaining <= remaining - BEATS_W'(1);
            if (!last_beat) begin
              lane <= lane + LANE_IDX_W'(1);
              if (last_lane) word_addr <= word_addr + ADDR_WIDTH'(8);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_osd_mam_mem_responder.sv
// Directed self-checking bench for osd_mam_mem_responder; the bench plays
// both the MAM initiator and the memory.
module tb_osd_mam_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_rw, req_burst;
  logic [31:0] req_addr;
  logic [13:0] req_beats;
  logic        write_valid, write_ready;
  logic [15:0] write_data;
  logic [1:0]  write_strb;
  logic        read_valid, read_ready;
  logic [15:0] read_data;
  logic        mem_req_valid, mem_req_ready, mem_req_we;
  logic [31:0] mem_req_addr;
  logic [63:0] mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [63:0] mem_rsp_rdata;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  localparam int TMO = 20;

  osd_mam_mem_responder dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_addr(req_addr), .req_burst(req_burst), .req_beats(req_beats),
    .write_valid(write_valid), .write_ready(write_ready),
    .write_data(write_data), .write_strb(write_strb),
    .read_valid(read_valid), .read_ready(read_ready), .read_data(read_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic rw, input logic [31:0] addr,
                        input logic burst, input logic [13:0] beats);
    int n = 0;
    req_valid = 1'b1; req_rw = rw; req_addr = addr;
    req_burst = burst; req_beats = beats;
    while (!req_ready && n < TMO) begin tick(); n++; end
    check("req_ready_wait", 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [15:0] data, input logic [1:0] strb);
    int n = 0;
    write_valid = 1'b1; write_data = data; write_strb = strb;
    while (!write_ready && n < TMO) begin tick(); n++; end
    check("write_ready_wait", 64'(write_ready), 64'd1);
    tick();
    write_valid = 1'b0;
  endtask

  task automatic expect_mem_write(input string tag, input logic [31:0] addr,
                                  input logic [63:0] wdata, input logic [7:0] wmask,
                                  input int stall);
    int n = 0;
    while (!mem_req_valid && n < TMO) begin tick(); n++; end
    for (int i = 0; i < stall; i++) begin
      check({tag, "_stall_valid"}, 64'(mem_req_valid), 64'd1);
      check({tag, "_stall_addr"}, 64'(mem_req_addr), 64'(addr));
      tick();
    end
    check({tag, "_valid"}, 64'(mem_req_valid), 64'd1);
    check({tag, "_we"},    64'(mem_req_we),    64'd1);
    check({tag, "_addr"},  64'(mem_req_addr),  64'(addr));
    check({tag, "_wdata"}, mem_req_wdata,      wdata);
    check({tag, "_wmask"}, 64'(mem_req_wmask), 64'(wmask));
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
  endtask

  task automatic expect_mem_read(input string tag, input logic [31:0] addr);
    int n = 0;
    while (!mem_req_valid && n < TMO) begin tick(); n++; end
    check({tag, "_valid"}, 64'(mem_req_valid), 64'd1);
    check({tag, "_we"},    64'(mem_req_we),    64'd0);
    check({tag, "_addr"},  64'(mem_req_addr),  64'(addr));
    check({tag, "_wmask"}, 64'(mem_req_wmask), 64'd0);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
  endtask

  task automatic respond(input string tag, input logic [63:0] rdata);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = rdata;
    tick();
    mem_rsp_valid = 1'b0;
    check({tag, "_rvalid_next"}, 64'(read_valid), 64'd1);
  endtask

  task automatic expect_beat(input string tag, input logic [15:0] data);
    int n = 0;
    read_ready = 1'b1;
    while (!read_valid && n < TMO) begin tick(); n++; end
    check({tag, "_rvalid"}, 64'(read_valid), 64'd1);
    check({tag, "_rdata"},  64'(read_data),  64'(data));
    tick();
    read_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 0; req_rw = 0; req_addr = '0; req_burst = 0; req_beats = '0;
    write_valid = 0; write_data = '0; write_strb = '0;
    read_ready = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_mem_valid", 64'(mem_req_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_read_data", 64'(read_data), 64'd0);
    check("rst_mem_addr", 64'(mem_req_addr), 64'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_req_ready", 64'(req_ready), 64'd1);

    // Single write into lane 1
    do_req(1'b1, 32'h8000_0002, 1'b0, 14'd0);
    check("w1_write_ready_t1", 64'(write_ready), 64'd1);
    check("w1_busy", 64'(busy), 64'd1);
    send_beat(16'hBEEF, 2'b11);
    check("w1_flush_next", 64'(mem_req_valid), 64'd1);
    check("w1_wready_low", 64'(write_ready), 64'd0);
    expect_mem_write("w1", 32'h8000_0000, 64'h0000_0000_BEEF_0000, 8'h0C, 0);
    check("w1_idle", 64'(busy), 64'd0);

    // Burst write of 6 beats from lane 2, with memory stall
    do_req(1'b1, 32'h8000_0004, 1'b1, 14'd6);
    send_beat(16'h0001, 2'b11);
    send_beat(16'h0002, 2'b11);
    expect_mem_write("w2a", 32'h8000_0000, 64'h0002_0001_0000_0000, 8'hF0, 3);
    for (int i = 3; i <= 6; i++) send_beat(16'(i), 2'b11);
    expect_mem_write("w2b", 32'h8000_0008, 64'h0006_0005_0004_0003, 8'hFF, 0);
    check("w2_idle", 64'(busy), 64'd0);

    // Burst read of 3 beats from lane 3
    do_req(1'b0, 32'h0002_0006, 1'b1, 14'd3);
    check("r1_memreq_t1", 64'(mem_req_valid), 64'd1);
    check("r1_wready_low", 64'(write_ready), 64'd0);
    expect_mem_read("r1a", 32'h0002_0000);
    check("r1_wait_no_rvalid", 64'(read_valid), 64'd0);
    respond("r1a", 64'h4444_3333_2222_1111);
    expect_beat("r1_b0", 16'h4444);
    expect_mem_read("r1b", 32'h0002_0008);
    respond("r1b", 64'h8888_7777_6666_5555);
    expect_beat("r1_b1", 16'h5555);
    check("r1_b2_b2b", 64'(read_valid), 64'd1);
    expect_beat("r1_b2", 16'h6666);
    check("r1_idle", 64'(busy), 64'd0);

    // Read backpressure: data stable, no new memory request until word drained
    do_req(1'b0, 32'h0000_1004, 1'b1, 14'd3);
    expect_mem_read("r2a", 32'h0000_1000);
    respond("r2a", 64'hDDDD_CCCC_BBBB_AAAA);
    for (int i = 0; i < 5; i++) begin
      check("r2_hold_valid", 64'(read_valid), 64'd1);
      check("r2_hold_data", 64'(read_data), 64'hCCCC);
      check("r2_hold_nomem", 64'(mem_req_valid), 64'd0);
      tick();
    end
    expect_beat("r2_b0", 16'hCCCC);
    for (int i = 0; i < 2; i++) begin
      check("r2_hold2_data", 64'(read_data), 64'hDDDD);
      check("r2_hold2_nomem", 64'(mem_req_valid), 64'd0);
      tick();
    end
    expect_beat("r2_b1", 16'hDDDD);
    expect_mem_read("r2b", 32'h0000_1008);
    respond("r2b", 64'h0000_0000_0000_EEEE);
    expect_beat("r2_b2", 16'hEEEE);
    check("r2_idle", 64'(busy), 64'd0);

    // Zero-strobe word is skipped; next word writes with partial strobes
    do_req(1'b1, 32'h0000_0040, 1'b1, 14'd8);
    for (int i = 0; i < 4; i++) send_beat(16'h5A5A, 2'b00);
    check("w3_skip_novalid", 64'(mem_req_valid), 64'd0);
    check("w3_skip_busy", 64'(busy), 64'd1);
    tick();
    check("w3_skip_back_collect", 64'(write_ready), 64'd1);
    check("w3_skip_addr", 64'(mem_req_addr), 64'h48);
    send_beat(16'h00A0, 2'b11);
    send_beat(16'h00A1, 2'b01);
    send_beat(16'h00A2, 2'b10);
    send_beat(16'h00A3, 2'b11);
    expect_mem_write("w3", 32'h0000_0048, 64'h00A3_00A2_00A1_00A0, 8'hE7, 0);
    check("w3_idle", 64'(busy), 64'd0);

    // Burst crossing the top of the address space wraps to zero
    do_req(1'b1, 32'hFFFF_FFFC, 1'b1, 14'd4);
    send_beat(16'h0011, 2'b11);
    send_beat(16'h0022, 2'b11);
    expect_mem_write("w4a", 32'hFFFF_FFF8, 64'h0022_0011_0000_0000, 8'hF0, 0);
    send_beat(16'h0033, 2'b11);
    send_beat(16'h0044, 2'b11);
    expect_mem_write("w4b", 32'h0000_0000, 64'h0000_0000_0044_0033, 8'h0F, 0);
    check("w4_idle", 64'(busy), 64'd0);

    // Reset while waiting for read data
    do_req(1'b0, 32'h0000_3000, 1'b0, 14'd0);
    expect_mem_read("r3", 32'h0000_3000);
    check("r3_in_wait", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("r3_rst_busy", 64'(busy), 64'd0);
    check("r3_rst_req_ready", 64'(req_ready), 64'd0);
    check("r3_rst_memvalid", 64'(mem_req_valid), 64'd0);
    check("r3_rst_rvalid", 64'(read_valid), 64'd0);
    check("r3_rst_addr", 64'(mem_req_addr), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("r3_post_req_ready", 64'(req_ready), 64'd1);
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    mem_rsp_valid = 1'b0;
    check("r3_stale_rvalid", 64'(read_valid), 64'd0);
    check("r3_stale_busy", 64'(busy), 64'd0);
    check("r3_stale_rdata", 64'(read_data), 64'd0);

    // Burst with zero beats acts as a single beat
    do_req(1'b0, 32'h0000_3000, 1'b1, 14'd0);
    expect_mem_read("r4", 32'h0000_3000);
    respond("r4", 64'h0000_0000_0000_1234);
    expect_beat("r4_b0", 16'h1234);
    check("r4_idle", 64'(busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
